// File: rtl/loadable_up_timer_if.sv
// Bus bundle for loadable_up_timer: control/data inputs and count/status outputs.
// tc_cnt is present only when LOADABLE_UP_TIMER_TC_CNT_EN is defined.
interface loadable_up_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] limit;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
    logic [7:0]       tc_cnt;
`endif

    modport master (
        output load, data, limit, en,
`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
        input  tc_cnt,
`endif
        input  count, tc, busy
    );

    modport slave (
        input  load, data, limit, en,
`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
        output tc_cnt,
`endif
        output count, tc, busy
    );
endinterface

// File: rtl/loadable_up_timer.sv
// Loadable up-counting timer: counts from a loaded start value to a run-time limit, pulses tc,
// then stops (WRAP=0) or wraps to 0 (WRAP=1). Define LOADABLE_UP_TIMER_TC_CNT_EN to add tc_cnt.
module loadable_up_timer #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b0
) (
    input logic                clk,
    input logic                rst,
    loadable_up_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count_q + 1'b1;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = bus.data;
            state_d = RUN;
        end else if (state_q == RUN && bus.en) begin
            if (WRAP && count_q == bus.limit) begin
                count_d = '0;
                tc_d    = (bus.limit == '0);
            end else begin
                // Loaded data==limit in one-shot mode lands here too: count on modulo 2^WIDTH.
                count_d = count_inc;
                tc_d    = (count_inc == bus.limit);
                if (!WRAP && tc_d) state_d = DONE;
            end
        end
        busy_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;

`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
    logic [7:0] tc_cnt_q, tc_cnt_d;

    always_comb begin
        tc_cnt_d = tc_cnt_q;
        if (bus.load)                       tc_cnt_d = 8'd0;
        else if (tc_d && tc_cnt_q != 8'hFF) tc_cnt_d = tc_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tc_cnt_q <= 8'd0;
        else     tc_cnt_q <= tc_cnt_d;
    end

    assign bus.tc_cnt = tc_cnt_q;
`endif
endmodule

// File: tb/tb_loadable_up_timer.sv
// Directed bench for loadable_up_timer: u_one (WRAP=0) and u_per (WRAP=1) share clk/rst.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_loadable_up_timer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    loadable_up_timer_if #(.WIDTH(4)) if0 ();
    loadable_up_timer_if #(.WIDTH(4)) if1 ();

    loadable_up_timer #(.WIDTH(4), .WRAP(1'b0)) u_one (.clk(clk), .rst(rst), .bus(if0));
    loadable_up_timer #(.WIDTH(4), .WRAP(1'b1)) u_per (.clk(clk), .rst(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({if0.count, if0.tc, if0.busy, if1.count, if1.tc, if1.busy} !== 12'h000) begin
            $display("FAIL reset_state: got %h expected 000", {if0.count, if0.tc, if0.busy, if1.count, if1.tc, if1.busy});
            n_fail++;
        end
`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
        n_checks++;
        if (if1.tc_cnt !== 8'd0) begin
            $display("FAIL reset_tc_cnt: got %0d expected 0", if1.tc_cnt);
            n_fail++;
        end
`endif
        rst = 1'b0;
        // Reset mid-count: reach count=5 in RUN, then assert rst between edges.
        if0.load = 1'b1; if0.data = 4'd5; if0.limit = 4'd12;
        tick();
        if0.load = 1'b0;
        n_checks++;
        if ({if0.count, if0.busy} !== {4'd5, 1'b1}) begin
            $display("FAIL reset_precond: got count=%0d busy=%b expected 5/1", if0.count, if0.busy);
            n_fail++;
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({if0.count, if0.tc, if0.busy} !== 6'd0) begin
            $display("FAIL reset_async: got count=%0d tc=%b busy=%b expected 0/0/0", if0.count, if0.tc, if0.busy);
            n_fail++;
        end
        #1 rst = 1'b0;
        if0.en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({if0.count, if0.tc, if0.busy} !== 6'd0) begin
                $display("FAIL reset_idle_en[%0d]: got count=%0d tc=%b busy=%b expected 0/0/0", i, if0.count, if0.tc, if0.busy);
                n_fail++;
            end
        end
        if0.en = 1'b0;
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_cnt [6] = '{4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6};
        logic       exp_tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_bsy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        if0.load = 1'b1; if0.data = 4'd3; if0.limit = 4'd6;
        tick();
        if0.load = 1'b0;
        n_checks++;
        if ({if0.count, if0.tc, if0.busy} !== {4'd3, 1'b0, 1'b1}) begin
            $display("FAIL one_shot_load: got count=%0d tc=%b busy=%b expected 3/0/1", if0.count, if0.tc, if0.busy);
            n_fail++;
        end
        if0.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({if0.count, if0.tc, if0.busy} !== {exp_cnt[i], exp_tc[i], exp_bsy[i]}) begin
                $display("FAIL one_shot[%0d]: got count=%0d tc=%b busy=%b expected %0d/%b/%b",
                         i, if0.count, if0.tc, if0.busy, exp_cnt[i], exp_tc[i], exp_bsy[i]);
                n_fail++;
            end
        end
        if0.en = 1'b0;
    endtask

    task automatic test_periodic();
        logic [3:0] exp_cnt [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
        logic       exp_tc  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        if1.load = 1'b1; if1.data = 4'd0; if1.limit = 4'd2;
        tick();
        if1.load = 1'b0;
        n_checks++;
        if ({if1.count, if1.tc, if1.busy} !== {4'd0, 1'b0, 1'b1}) begin
            $display("FAIL periodic_load: got count=%0d tc=%b busy=%b expected 0/0/1", if1.count, if1.tc, if1.busy);
            n_fail++;
        end
        if1.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({if1.count, if1.tc, if1.busy} !== {exp_cnt[i], exp_tc[i], 1'b1}) begin
                $display("FAIL periodic[%0d]: got count=%0d tc=%b busy=%b expected %0d/%b/1",
                         i, if1.count, if1.tc, if1.busy, exp_cnt[i], exp_tc[i]);
                n_fail++;
            end
        end
        if1.en = 1'b0;
    endtask

    task automatic test_wrap_through();
        logic [3:0] exp_cnt [3] = '{4'd15, 4'd0, 4'd1};
        logic       exp_tc  [3] = '{1'b0, 1'b0, 1'b1};
        logic       exp_bsy [3] = '{1'b1, 1'b1, 1'b0};
        if0.load = 1'b1; if0.data = 4'd14; if0.limit = 4'd1;
        tick();
        if0.load = 1'b0;
        n_checks++;
        if ({if0.count, if0.tc} !== {4'd14, 1'b0}) begin
            $display("FAIL wrap_through_load: got count=%0d tc=%b expected 14/0", if0.count, if0.tc);
            n_fail++;
        end
        if0.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if0.count, if0.tc, if0.busy} !== {exp_cnt[i], exp_tc[i], exp_bsy[i]}) begin
                $display("FAIL wrap_through[%0d]: got count=%0d tc=%b busy=%b expected %0d/%b/%b",
                         i, if0.count, if0.tc, if0.busy, exp_cnt[i], exp_tc[i], exp_bsy[i]);
                n_fail++;
            end
        end
        if0.en = 1'b0;
    endtask

    task automatic test_priority_restart();
        if0.load = 1'b1; if0.data = 4'd0; if0.limit = 4'd10;
        tick();
        if0.load = 1'b0; if0.en = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({if0.count, if0.busy} !== {4'd4, 1'b1}) begin
            $display("FAIL restart_precond: got count=%0d busy=%b expected 4/1", if0.count, if0.busy);
            n_fail++;
        end
        if0.load = 1'b1; if0.data = 4'd9;
        tick();
        n_checks++;
        if ({if0.count, if0.tc, if0.busy} !== {4'd9, 1'b0, 1'b1}) begin
            $display("FAIL restart_load: got count=%0d tc=%b busy=%b expected 9/0/1", if0.count, if0.tc, if0.busy);
            n_fail++;
        end
        if0.load = 1'b0; if0.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if0.count, if0.tc, if0.busy} !== {4'd9, 1'b0, 1'b1}) begin
                $display("FAIL restart_hold[%0d]: got count=%0d tc=%b busy=%b expected 9/0/1", i, if0.count, if0.tc, if0.busy);
                n_fail++;
            end
        end
    endtask

    task automatic test_load_eq_limit();
        if0.load = 1'b1; if0.data = 4'd5; if0.limit = 4'd5;
        tick();
        if0.load = 1'b0;
        n_checks++;
        if ({if0.count, if0.tc, if0.busy} !== {4'd5, 1'b0, 1'b1}) begin
            $display("FAIL eq_limit_load: got count=%0d tc=%b busy=%b expected 5/0/1", if0.count, if0.tc, if0.busy);
            n_fail++;
        end
        if0.en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            n_checks++;
            if ({if0.count, if0.tc, if0.busy} !== {4'((5 + i) % 16), 1'b0, 1'b1}) begin
                $display("FAIL eq_limit_step[%0d]: got count=%0d tc=%b busy=%b expected %0d/0/1",
                         i, if0.count, if0.tc, if0.busy, (5 + i) % 16);
                n_fail++;
            end
        end
        tick();
        n_checks++;
        if ({if0.count, if0.tc, if0.busy} !== {4'd5, 1'b1, 1'b0}) begin
            $display("FAIL eq_limit_final: got count=%0d tc=%b busy=%b expected 5/1/0", if0.count, if0.tc, if0.busy);
            n_fail++;
        end
        if0.en = 1'b0;
    endtask

    task automatic test_limit_zero();
        if1.load = 1'b1; if1.data = 4'd0; if1.limit = 4'd0;
        tick();
        if1.load = 1'b0;
        n_checks++;
        if ({if1.count, if1.tc} !== {4'd0, 1'b0}) begin
            $display("FAIL limit_zero_load: got count=%0d tc=%b expected 0/0", if1.count, if1.tc);
            n_fail++;
        end
        if1.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if1.count, if1.tc, if1.busy} !== {4'd0, 1'b1, 1'b1}) begin
                $display("FAIL limit_zero[%0d]: got count=%0d tc=%b busy=%b expected 0/1/1", i, if1.count, if1.tc, if1.busy);
                n_fail++;
            end
        end
        if1.en = 1'b0;
        tick();
        n_checks++;
        if (if1.tc !== 1'b0) begin
            $display("FAIL limit_zero_en_off: got tc=%b expected 0", if1.tc);
            n_fail++;
        end
    endtask

`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
    task automatic test_tc_cnt();
        if1.load = 1'b1; if1.data = 4'd0; if1.limit = 4'd1;
        tick();
        if1.load = 1'b0; if1.en = 1'b1;
        // limit=1 from 0: tc on enabled edges 1,3,5,7,9 -> 5 pulses after 10 edges.
        repeat (10) tick();
        n_checks++;
        if (if1.tc_cnt !== 8'd5) begin
            $display("FAIL tc_cnt_partial: got %0d expected 5", if1.tc_cnt);
            n_fail++;
        end
        repeat (590) tick();
        n_checks++;
        if (if1.tc_cnt !== 8'd255) begin
            $display("FAIL tc_cnt_saturate: got %0d expected 255", if1.tc_cnt);
            n_fail++;
        end
        if1.load = 1'b1;
        tick();
        if1.load = 1'b0; if1.en = 1'b0;
        n_checks++;
        if (if1.tc_cnt !== 8'd0) begin
            $display("FAIL tc_cnt_load_clear: got %0d expected 0", if1.tc_cnt);
            n_fail++;
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        if0.load = 1'b0; if0.data = '0; if0.limit = '0; if0.en = 1'b0;
        if1.load = 1'b0; if1.data = '0; if1.limit = '0; if1.en = 1'b0;
        test_reset();
        test_one_shot();
        test_periodic();
        test_wrap_through();
        test_priority_restart();
        test_load_eq_limit();
        test_limit_zero();
`ifdef LOADABLE_UP_TIMER_TC_CNT_EN
        test_tc_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
